// File: rtl/light_sequencer_if.sv
// Phase-controller bundle between the light sequencer and its phase counter / pedestrian button.
// The master side is the sequencer; the slave side is the counter and button environment.
interface light_sequencer_if #(
   parameter int CW = 4
);
   logic          pedestrian;
   logic [CW-1:0] counter_reg;
   logic [1:0]    currColour;
   logic          count_rst;
   logic          lamp_red;
   logic          lamp_amber;
   logic          lamp_green;
   logic          walk;
   logic          ped_wait;

   modport master (
      input  pedestrian, counter_reg,
      output currColour, count_rst, lamp_red, lamp_amber, lamp_green, walk, ped_wait
   );

   modport slave (
      output pedestrian, counter_reg,
      input  currColour, count_rst, lamp_red, lamp_amber, lamp_green, walk, ped_wait
   );
endinterface

// File: rtl/light_sequencer.sv
// Traffic-light phase controller: RED -> GREEN -> AMBER -> RED, driven by an external phase counter.
// All outputs registered; one-cycle count_rst pulse on every phase change; pedestrian requests shorten GREEN.
module light_sequencer #(
   parameter int CW         = 4,
   parameter int RED_TERM   = 9,
   parameter int GREEN_TERM = 7,
   parameter int AMBER_TERM = 3,
   parameter int GREEN_MIN  = 3
) (
   input  logic               second_clk,
   input  logic               reset,
   light_sequencer_if.master  bus
);
   typedef enum logic [1:0] {
      RED     = 2'b00,
      AMBER   = 2'b01,
      ILLEGAL = 2'b10,
      GREEN   = 2'b11
   } state_t;

   localparam logic [CW-1:0] RED_T   = CW'(RED_TERM);
   localparam logic [CW-1:0] GREEN_T = CW'(GREEN_TERM);
   localparam logic [CW-1:0] AMBER_T = CW'(AMBER_TERM);
   localparam logic [CW-1:0] GMIN_T  = CW'(GREEN_MIN);

   state_t     state_q, state_d;
   logic       count_rst_q, count_rst_d;
   logic       walk_q, walk_d;
   logic       ped_req_q, ped_req_d;
   logic [2:0] lamps_q, lamps_d;   // {red, amber, green}
   logic       ped_pending;
   logic       can_adv;

   always_comb begin
      state_d     = state_q;
      walk_d      = walk_q;
      // The button is ignored while the walk lamp is lit.
      ped_pending = ped_req_q | (bus.pedestrian & ~walk_q);
      ped_req_d   = ped_pending;
      can_adv     = ~count_rst_q;

      case (state_q)
         RED: begin
            if (can_adv && bus.counter_reg == RED_T) begin
               state_d = GREEN;
               walk_d  = 1'b0;
            end
         end
         GREEN: begin
            if (can_adv && (bus.counter_reg == GREEN_T ||
                            (ped_pending && bus.counter_reg >= GMIN_T &&
                             bus.counter_reg <= GREEN_T))) begin
               state_d = AMBER;
            end
         end
         AMBER: begin
            if (can_adv && bus.counter_reg == AMBER_T) begin
               state_d   = RED;
               walk_d    = ped_req_q | bus.pedestrian;
               ped_req_d = 1'b0;
            end
         end
         ILLEGAL: begin
            state_d = RED;
         end
      endcase

      count_rst_d = (state_d != state_q);
      lamps_d     = {state_d == RED, state_d == AMBER, state_d == GREEN};
   end

   always_ff @(posedge second_clk) begin
      if (reset) begin
         state_q     <= RED;
         count_rst_q <= 1'b1;
         walk_q      <= 1'b0;
         ped_req_q   <= 1'b0;
         lamps_q     <= 3'b100;
      end else begin
         state_q     <= state_d;
         count_rst_q <= count_rst_d;
         walk_q      <= walk_d;
         ped_req_q   <= ped_req_d;
         lamps_q     <= lamps_d;
      end
   end

   assign bus.currColour = state_q;
   assign bus.count_rst  = count_rst_q;
   assign bus.lamp_red   = lamps_q[2];
   assign bus.lamp_amber = lamps_q[1];
   assign bus.lamp_green = lamps_q[0];
   assign bus.walk       = walk_q;
   assign bus.ped_wait   = ped_req_q;
endmodule
